i_decode: RTL and testbench

//  RV32I instruction decode stage: consumes fetch-stage pipeline outputs (instr, PC, PC+4),

---
 rtl/riscv_pkg.sv | 101 ++++++++++
 rtl/reg_file.sv | 53 +++++
 rtl/i_decode.sv | 199 +++++++++++++++++++
 tb/tb_i_decode.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, decode enums, control word and immediate helpers.
`default_nettype none

package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_ADDPC = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_MEM  = 2'd1,
        RES_PC4  = 2'd2,
        RES_RSVD = 2'd3
    } result_sel_e;

    typedef struct packed {
        logic        reg_wr;
        logic        mem_wr;
        result_sel_e result_sel;
        alu_op_e     alu_op;
        logic        alu_src;
        logic        branch;
        logic        jump;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Takes instr[31:7]; the opcode bits never contribute to an immediate.
    function automatic logic [31:0] gen_imm(input logic [31:7] ins, input imm_type_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm = {ins[31:12], 12'b0};
            IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

    // alt is instr[30]; it selects SUB only for register-register ops, SRA for both.
    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt, input logic is_op);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_e alu_for_branch(input logic [2:1] f3_hi);
        alu_op_e op;
        case (f3_hi)
            2'b10:   op = ALU_SLT;
            2'b11:   op = ALU_SLTU;
            default: op = ALU_SUB;
        endcase
        return op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// reg_file: 2R1W architectural register file, async read, x0 hardwired to zero.
// Macro WB_BYPASS_EN: a same-cycle write is forwarded to a matching read port.
`default_nettype none

module reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [$clog2(NUM_REGS)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr_i,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr_i,
    output logic [DATA_W-1:0]           rs1_data_o,
    output logic [DATA_W-1:0]           rs2_data_o
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] data;
        if (addr == '0) begin
            data = '0;
`ifdef WB_BYPASS_EN
        end else if (wr_en_i && (wr_addr_i == addr)) begin
            data = wr_data_i;
`endif
        end else begin
            data = regs_q[addr];
        end
        return data;
    endfunction

    assign rs1_data_o = read_port(rs1_addr_i);
    assign rs2_data_o = read_port(rs2_addr_i);

endmodule

`default_nettype wire

// File: rtl/i_decode.sv
// i_decode: RV32I decode stage -- control/immediate generation, register read, ID/EX register.
// Macro WB_BYPASS_EN: register reads see a writeback issued in the same cycle.
`default_nettype none

module i_decode
    import riscv_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGS    = 32
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_stall,
    input  logic                        i_flush,
    input  logic [INSTR_WIDTH-1:0]      i_IF_instr,
    input  logic [ADDR_WIDTH-1:0]       i_IF_program_cntr,
    input  logic [ADDR_WIDTH-1:0]       i_IF_program_cntr_next,
    input  logic                        i_WB_reg_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] i_WB_rd_addr,
    input  logic [INSTR_WIDTH-1:0]      i_WB_rd_data,
    output logic                        o_ID_valid,
    output logic                        o_ID_illegal,
    output logic [INSTR_WIDTH-1:0]      o_ID_rs1_data,
    output logic [INSTR_WIDTH-1:0]      o_ID_rs2_data,
    output logic [$clog2(NUM_REGS)-1:0] o_ID_rs1_addr,
    output logic [$clog2(NUM_REGS)-1:0] o_ID_rs2_addr,
    output logic [$clog2(NUM_REGS)-1:0] o_ID_rd_addr,
    output logic [INSTR_WIDTH-1:0]      o_ID_imm,
    output logic [ADDR_WIDTH-1:0]       o_ID_program_cntr,
    output logic [ADDR_WIDTH-1:0]       o_ID_program_cntr_next,
    output ctrl_t                       o_ID_ctrl
);

    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic                   valid;
        logic                   illegal;
        logic [INSTR_WIDTH-1:0] rs1_data;
        logic [INSTR_WIDTH-1:0] rs2_data;
        logic [REG_ADDR_W-1:0]  rs1_addr;
        logic [REG_ADDR_W-1:0]  rs2_addr;
        logic [REG_ADDR_W-1:0]  rd_addr;
        logic [INSTR_WIDTH-1:0] imm;
        logic [ADDR_WIDTH-1:0]  pc;
        logic [ADDR_WIDTH-1:0]  pc_next;
        ctrl_t                  ctrl;
    } idex_t;

    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic                  w_alt;
    logic [REG_ADDR_W-1:0] w_rs1_addr;
    logic [REG_ADDR_W-1:0] w_rs2_addr;
    logic [REG_ADDR_W-1:0] w_rd_addr;
    logic [INSTR_WIDTH-1:0] w_rs1_data;
    logic [INSTR_WIDTH-1:0] w_rs2_data;
    imm_type_e             w_imm_type;
    ctrl_t                 w_ctrl;
    logic                  w_legal;
    idex_t                 w_load;
    idex_t                 idex_d;
    idex_t                 idex_q;

    assign w_opcode   = i_IF_instr[6:0];
    assign w_funct3   = i_IF_instr[14:12];
    assign w_alt      = i_IF_instr[30];
    assign w_rd_addr  = i_IF_instr[7 +: REG_ADDR_W];
    assign w_rs1_addr = i_IF_instr[15 +: REG_ADDR_W];
    assign w_rs2_addr = i_IF_instr[20 +: REG_ADDR_W];

    reg_file #(
        .DATA_W   (INSTR_WIDTH),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk_i      (i_clk),
        .rst_ni     (i_reset_n),
        .wr_en_i    (i_WB_reg_wr_en),
        .wr_addr_i  (i_WB_rd_addr),
        .wr_data_i  (i_WB_rd_data),
        .rs1_addr_i (w_rs1_addr),
        .rs2_addr_i (w_rs2_addr),
        .rs1_data_o (w_rs1_data),
        .rs2_data_o (w_rs2_data)
    );

    // Unknown opcodes fall through with an all-zero control word so nothing downstream writes.
    always_comb begin
        w_ctrl     = CTRL_NOP;
        w_imm_type = IMM_R;
        w_legal    = 1'b1;
        case (w_opcode)
            OPC_LUI: begin
                w_imm_type     = IMM_U;
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.alu_op  = ALU_PASSB;
                w_ctrl.alu_src = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm_type     = IMM_U;
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.alu_op  = ALU_ADDPC;
                w_ctrl.alu_src = 1'b1;
            end
            OPC_JAL: begin
                w_imm_type        = IMM_J;
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.result_sel = RES_PC4;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.jump       = 1'b1;
            end
            OPC_JALR: begin
                w_imm_type        = IMM_I;
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.result_sel = RES_PC4;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.jump       = 1'b1;
            end
            OPC_BRANCH: begin
                w_imm_type    = IMM_B;
                w_ctrl.alu_op = alu_for_branch(w_funct3[2:1]);
                w_ctrl.branch = 1'b1;
            end
            OPC_LOAD: begin
                w_imm_type        = IMM_I;
                w_ctrl.reg_wr     = 1'b1;
                w_ctrl.result_sel = RES_MEM;
                w_ctrl.alu_src    = 1'b1;
            end
            OPC_STORE: begin
                w_imm_type     = IMM_S;
                w_ctrl.mem_wr  = 1'b1;
                w_ctrl.alu_src = 1'b1;
            end
            OPC_OP_IMM: begin
                w_imm_type     = IMM_I;
                w_ctrl.reg_wr  = 1'b1;
                w_ctrl.alu_op  = alu_from_funct(w_funct3, w_alt, 1'b0);
                w_ctrl.alu_src = 1'b1;
            end
            OPC_OP: begin
                w_ctrl.reg_wr = 1'b1;
                w_ctrl.alu_op = alu_from_funct(w_funct3, w_alt, 1'b1);
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_load          = '0;
        w_load.valid    = w_legal;
        w_load.illegal  = ~w_legal;
        w_load.rs1_data = w_rs1_data;
        w_load.rs2_data = w_rs2_data;
        w_load.rs1_addr = w_rs1_addr;
        w_load.rs2_addr = w_rs2_addr;
        w_load.rd_addr  = w_rd_addr;
        w_load.imm      = gen_imm(i_IF_instr[31:7], w_imm_type);
        w_load.pc       = i_IF_program_cntr;
        w_load.pc_next  = i_IF_program_cntr_next;
        w_load.ctrl     = w_ctrl;
    end

    // Flush wins over stall so a squashed slot never survives a concurrent hold.
    always_comb begin
        idex_d = idex_q;
        if (i_flush) begin
            idex_d = '0;
        end else if (!i_stall) begin
            idex_d = w_load;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign o_ID_valid             = idex_q.valid;
    assign o_ID_illegal           = idex_q.illegal;
    assign o_ID_rs1_data          = idex_q.rs1_data;
    assign o_ID_rs2_data          = idex_q.rs2_data;
    assign o_ID_rs1_addr          = idex_q.rs1_addr;
    assign o_ID_rs2_addr          = idex_q.rs2_addr;
    assign o_ID_rd_addr           = idex_q.rd_addr;
    assign o_ID_imm               = idex_q.imm;
    assign o_ID_program_cntr      = idex_q.pc;
    assign o_ID_program_cntr_next = idex_q.pc_next;
    assign o_ID_ctrl              = idex_q.ctrl;

endmodule

`default_nettype wire

// File: tb/tb_i_decode.sv
// tb_i_decode: directed scoreboard bench for the i_decode stage.
`default_nettype none

module tb_i_decode;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc_in = '0;
    logic [31:0] pcn_in = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;

    logic        o_valid;
    logic        o_illegal;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [4:0]  o_rs1_addr;
    logic [4:0]  o_rs2_addr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_imm;
    logic [31:0] o_pc;
    logic [31:0] o_pcn;
    ctrl_t       o_ctrl;

    always #5 clk = ~clk;

    i_decode u_dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_stall                (stall),
        .i_flush                (flush),
        .i_IF_instr             (instr),
        .i_IF_program_cntr      (pc_in),
        .i_IF_program_cntr_next (pcn_in),
        .i_WB_reg_wr_en         (wb_en),
        .i_WB_rd_addr           (wb_addr),
        .i_WB_rd_data           (wb_data),
        .o_ID_valid             (o_valid),
        .o_ID_illegal           (o_illegal),
        .o_ID_rs1_data          (o_rs1_data),
        .o_ID_rs2_data          (o_rs2_data),
        .o_ID_rs1_addr          (o_rs1_addr),
        .o_ID_rs2_addr          (o_rs2_addr),
        .o_ID_rd_addr           (o_rd_addr),
        .o_ID_imm               (o_imm),
        .o_ID_program_cntr      (o_pc),
        .o_ID_program_cntr_next (o_pcn),
        .o_ID_ctrl              (o_ctrl)
    );

    typedef struct {
        string       tag;
        logic        valid;
        logic        illegal;
        logic [10:0] ctrl;
        logic [31:0] imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pcn;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_exp;
    logic [31:0] model [32];
    logic [31:0] pc_ctr = 32'h0000_0100;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic exp_t zero_exp(input string tag);
        exp_t e;
        e.tag = tag;   e.valid = 1'b0; e.illegal = 1'b0; e.ctrl = '0;
        e.imm = '0;    e.rs1d = '0;    e.rs2d = '0;
        e.rs1 = '0;    e.rs2 = '0;     e.rd = '0;
        e.pc = '0;     e.pcn = '0;
        return e;
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return model[a];
    endfunction

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
            return;
        end
        e = sb_q.pop_front();
        chk(e.tag, "valid",    {31'd0, o_valid},    {31'd0, e.valid});
        chk(e.tag, "illegal",  {31'd0, o_illegal},  {31'd0, e.illegal});
        chk(e.tag, "ctrl",     {21'd0, o_ctrl},     {21'd0, e.ctrl});
        chk(e.tag, "imm",      o_imm,               e.imm);
        chk(e.tag, "rs1_data", o_rs1_data,          e.rs1d);
        chk(e.tag, "rs2_data", o_rs2_data,          e.rs2d);
        chk(e.tag, "rs1_addr", {27'd0, o_rs1_addr}, {27'd0, e.rs1});
        chk(e.tag, "rs2_addr", {27'd0, o_rs2_addr}, {27'd0, e.rs2});
        chk(e.tag, "rd_addr",  {27'd0, o_rd_addr},  {27'd0, e.rd});
        chk(e.tag, "pc",       o_pc,                e.pc);
        chk(e.tag, "pc_next",  o_pcn,               e.pcn);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
        last_exp = zero_exp("reset");
    endtask

    // Drive one fetch slot (plus optional writeback), predict the ID/EX contents, clock, compare.
    task automatic step(input string tag, input logic [31:0] ins, input logic st, input logic fl,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] x_imm, input logic [10:0] x_ctrl,
                        input logic x_valid, input logic x_illegal);
        exp_t e;
        instr = ins; pc_in = pc_ctr; pcn_in = pc_ctr + 32'd4;
        stall = st; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
        if (fl) begin
            e = zero_exp(tag);
        end else if (st) begin
            e = last_exp;
            e.tag = tag;
        end else begin
            e.tag = tag; e.valid = x_valid; e.illegal = x_illegal;
            e.ctrl = x_ctrl; e.imm = x_imm;
            e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
            e.rs1d = rd_model(e.rs1, we, wa, wd);
            e.rs2d = rd_model(e.rs2, we, wa, wd);
            e.pc = pc_ctr; e.pcn = pc_ctr + 32'd4;
        end
        sb_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        check_out();
        if (we && wa != 5'd0) model[wa] = wd;
        pc_ctr += 32'd4;
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD_X1_X5_X0 = 32'h0002_80B3;
    localparam logic [31:0] ADD_X8_X7_X7 = 32'h0073_8433;

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(zero_exp("reset"));
        check_out();

        @(negedge clk);
        rst_n = 1'b1;

        //   tag            instr          st fl we  wa     wd             imm            ctrl    v  il
        step("wb_x5",       NOP,           0, 0, 1, 5'd5,  32'hDEAD_BEEF, 32'h0,         11'h404, 1, 0);
        step("add_x1",      ADD_X1_X5_X0,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h400, 1, 0);
        step("addi_m1",     32'hFFF00113,  0, 0, 0, 5'd0,  32'h0,         32'hFFFF_FFFF, 11'h404, 1, 0);
        step("beq_m4",      32'hFE000EE3,  0, 0, 0, 5'd0,  32'h0,         32'hFFFF_FFFC, 11'h00A, 1, 0);
        step("lui",         32'h12345237,  0, 0, 0, 5'd0,  32'h0,         32'h1234_5000, 11'h454, 1, 0);
        step("jal_p8",      32'h008000EF,  0, 0, 0, 5'd0,  32'h0,         32'h0000_0008, 11'h505, 1, 0);
        step("sw_m8",       32'hFE512C23,  0, 0, 0, 5'd0,  32'h0,         32'hFFFF_FFF8, 11'h204, 1, 0);
        step("wb_x0",       NOP,           0, 0, 1, 5'd0,  32'h0000_1234, 32'h0,         11'h404, 1, 0);
        step("add_x3_x0",   32'h000001B3,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h400, 1, 0);
        step("addi_x9",     32'h00500493,  0, 0, 0, 5'd0,  32'h0,         32'h0000_0005, 11'h404, 1, 0);
        step("stall1",      32'h12345237,  1, 0, 0, 5'd0,  32'h0,         32'h0,         11'h000, 0, 0);
        step("stall2_wb",   ADD_X1_X5_X0,  1, 0, 1, 5'd7,  32'h0000_1111, 32'h0,         11'h000, 0, 0);
        step("stall3",      32'hFE000EE3,  1, 0, 0, 5'd0,  32'h0,         32'h0,         11'h000, 0, 0);
        step("flush_stall", 32'h00500493,  1, 1, 0, 5'd0,  32'h0,         32'h0,         11'h000, 0, 0);
        step("wb_bypass",   ADD_X8_X7_X7,  0, 0, 1, 5'd7,  32'h0000_A5A5, 32'h0,         11'h400, 1, 0);
        step("add_x8_next", ADD_X8_X7_X7,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h400, 1, 0);
        step("illegal_7f",  32'h0000007F,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h000, 0, 1);
        step("illegal_0",   32'h00000000,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h000, 0, 1);
        step("flush_only",  ADD_X1_X5_X0,  0, 1, 0, 5'd0,  32'h0,         32'h0,         11'h000, 0, 0);
        step("add_x1_pre",  ADD_X1_X5_X0,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h400, 1, 0);

        // Reset mid-cycle: outputs must clear before the next rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.push_back(zero_exp("async_reset"));
        check_out();
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;

        step("add_x1_post", ADD_X1_X5_X0,  0, 0, 0, 5'd0,  32'h0,         32'h0,         11'h400, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
